// File: rtl/mysystem_seq_pkg.sv
// Shared definitions for the start sequencer: FSM state encoding and the
// bit positions of the status word as software reads it back.
// Imported by the top module and the step prescaler.
package mysystem_seq_pkg;

  // Run sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  // Status bit positions in the readback input PIO word.
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_DONE     = 1;
  localparam int unsigned STAT_ABORTED  = 2;
  localparam int unsigned STAT_ZERO_LEN = 3;
  localparam int unsigned STAT_W        = 4;

endpackage

// File: rtl/mysystem_step_prescaler.sv
// Step prescaler: counts 0..PRESCALE-1 while enabled and wraps, with a
// synchronous clear. tick is combinational and high on the terminal count.
// Ports: clk, reset (async, active-high), en, clr -> tick.
module mysystem_step_prescaler
  import mysystem_seq_pkg::*;
#(
  parameter int unsigned PRESCALE = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mysystem_start_sequencer.sv
// Start sequencer: turns a rising edge on the software start level into one
// run of run_len prescaled step pulses, with busy/done/aborted/zero_len status.
// Ports: clk, reset, start_in, run_len, abort, done_ack -> busy, step,
//        steps_done, done, aborted, zero_len.
module mysystem_start_sequencer
  import mysystem_seq_pkg::*;
#(
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned PRESCALE = 50
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic [LEN_W-1:0] run_len,
  input  logic             abort,
  input  logic             done_ack,
  output logic             busy,
  output logic             step,
  output logic [LEN_W-1:0] steps_done,
  output logic             done,
  output logic             aborted,
  output logic             zero_len
);

  seq_state_e       state_q, state_d;
  logic             start_d_q;
  logic             busy_q, busy_d;
  logic             step_q, step_d;
  logic [LEN_W-1:0] steps_done_q, steps_done_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             zero_len_q, zero_len_d;

  logic rise;
  logic accept;
  logic tick;
  logic last_step;

  // start_d_q resets high so a level already held at reset release is not
  // mistaken for a fresh request.
  assign rise      = start_in & ~start_d_q;
  // Starts are only honoured outside a run; there is no queuing.
  assign accept    = rise && (state_q != ST_RUN);
  assign last_step = (remaining_q == LEN_W'(1));

  // Counter held at zero outside RUN, so every run begins at count 0.
  // Abort also clears it so nothing leaks into the next run.
  mysystem_step_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == ST_RUN),
    .clr  ((state_q != ST_RUN) || abort),
    .tick (tick)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (rise) begin
          state_d = (run_len != '0) ? ST_RUN : ST_DONE;
        end else if ((state_q == ST_DONE) && done_ack) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // Abort outranks a coinciding terminal tick.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick && last_step) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    busy_d       = (state_d == ST_RUN);
    step_d       = 1'b0;
    steps_done_d = steps_done_q;
    remaining_d  = remaining_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    zero_len_d   = zero_len_q;

    if (accept) begin
      // An accepted start always resets the counters and all flags; a
      // zero-length request completes immediately as a flagged no-op run.
      steps_done_d = '0;
      remaining_d  = run_len;
      aborted_d    = 1'b0;
      done_d       = (run_len == '0);
      zero_len_d   = (run_len == '0);
    end else begin
      case (state_q)
        ST_RUN: begin
          if (abort) begin
            aborted_d = 1'b1;
          end else if (tick) begin
            step_d       = 1'b1;
            steps_done_d = steps_done_q + LEN_W'(1);
            remaining_d  = remaining_q - LEN_W'(1);
            if (last_step) begin
              done_d = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (done_ack) begin
            done_d     = 1'b0;
            zero_len_d = 1'b0;
            aborted_d  = 1'b0;
          end
        end
        ST_IDLE: begin
          if (done_ack) begin
            aborted_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_d_q    <= 1'b1;
      busy_q       <= 1'b0;
      step_q       <= 1'b0;
      steps_done_q <= '0;
      remaining_q  <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      zero_len_q   <= 1'b0;
    end else begin
      start_d_q    <= start_in;
      busy_q       <= busy_d;
      step_q       <= step_d;
      steps_done_q <= steps_done_d;
      remaining_q  <= remaining_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      zero_len_q   <= zero_len_d;
    end
  end

  assign busy       = busy_q;
  assign step       = step_q;
  assign steps_done = steps_done_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign zero_len   = zero_len_q;

endmodule

// File: tb/tb_mysystem_start_sequencer.sv
// Bench for mysystem_start_sequencer with PRESCALE=4: a per-cycle vector
// table for the basic run / zero-length run, then hand-written sequences
// for abort, ignored restart, ack+start collision and async reset.
module tb_mysystem_start_sequencer;

  localparam int unsigned LEN_W    = 16;
  localparam int unsigned PRESCALE = 4;

  logic             clk;
  logic             reset;
  logic             start_in;
  logic [LEN_W-1:0] run_len;
  logic             abort;
  logic             done_ack;
  logic             busy;
  logic             step;
  logic [LEN_W-1:0] steps_done;
  logic             done;
  logic             aborted;
  logic             zero_len;

  int n_checks;
  int n_fail;
  int step_cnt;

  mysystem_start_sequencer #(
    .LEN_W   (LEN_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_in  (start_in),
    .run_len   (run_len),
    .abort     (abort),
    .done_ack  (done_ack),
    .busy      (busy),
    .step      (step),
    .steps_done(steps_done),
    .done      (done),
    .aborted   (aborted),
    .zero_len  (zero_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             s;
    logic [LEN_W-1:0] len;
    logic             ab;
    logic             ack;
    logic             busy;
    logic             step;
    logic [LEN_W-1:0] sd;
    logic             done;
    logic             abrt;
    logic             zl;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input int len, input logic ab, input logic ack,
                              input logic b, input logic st, input int sd,
                              input logic d, input logic a, input logic z);
    vec_t v;
    v.s = s; v.len = LEN_W'(len); v.ab = ab; v.ack = ack;
    v.busy = b; v.step = st; v.sd = LEN_W'(sd); v.done = d; v.abrt = a; v.zl = z;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LEN_W-1:0] act, input logic [LEN_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges, sampling 1 time unit after each, counting steps.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (step === 1'b1) step_cnt++;
    end
  endtask

  task automatic chk_all(input string tag, input logic b, input logic st, input int sd,
                         input logic d, input logic a, input logic z);
    chk({tag, "_busy"}, LEN_W'(busy), LEN_W'(b));
    chk({tag, "_step"}, LEN_W'(step), LEN_W'(st));
    chk({tag, "_steps_done"}, steps_done, LEN_W'(sd));
    chk({tag, "_done"}, LEN_W'(done), LEN_W'(d));
    chk({tag, "_aborted"}, LEN_W'(aborted), LEN_W'(a));
    chk({tag, "_zero_len"}, LEN_W'(zero_len), LEN_W'(z));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    step_cnt = 0;
    reset    = 1'b1;
    start_in = 1'b1;
    run_len  = '0;
    abort    = 1'b0;
    done_ack = 1'b0;

    // Each row: inputs applied before an edge, outputs expected after it.
    //             s  len ab ack | busy step sd done abrt zl
    vq.push_back(mk(1, 3, 0, 0,   0, 0, 0, 0, 0, 0)); // start held through reset
    vq.push_back(mk(1, 3, 0, 0,   0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 3, 0, 0,   0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 0, 0, 0, 0)); // rise -> busy
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 1, 1, 0, 0, 0)); // busy+4
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 1, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 1, 2, 0, 0, 0)); // busy+8
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 2, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 2, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   1, 0, 2, 0, 0, 0));
    vq.push_back(mk(1, 3, 0, 0,   0, 1, 3, 1, 0, 0)); // busy+12, done with last step
    vq.push_back(mk(1, 3, 0, 0,   0, 0, 3, 1, 0, 0));
    vq.push_back(mk(0, 3, 0, 1,   0, 0, 3, 0, 0, 0)); // ack -> IDLE
    vq.push_back(mk(1, 0, 0, 0,   0, 0, 0, 1, 0, 1)); // zero-length start
    vq.push_back(mk(1, 0, 0, 0,   0, 0, 0, 1, 0, 1));
    vq.push_back(mk(0, 0, 0, 1,   0, 0, 0, 0, 0, 0)); // ack clears done/zero_len
    vq.push_back(mk(0, 0, 1, 0,   0, 0, 0, 0, 0, 0)); // abort in IDLE ignored

    // Reset state.
    cyc(2);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    foreach (vq[i]) begin
      start_in = vq[i].s;
      run_len  = vq[i].len;
      abort    = vq[i].ab;
      done_ack = vq[i].ack;
      cyc(1);
      chk_all($sformatf("v%0d", i), vq[i].busy, vq[i].step, int'(vq[i].sd),
              vq[i].done, vq[i].abrt, vq[i].zl);
    end
    abort = 1'b0;

    // Abort 10 cycles after busy in a 5-step run.
    start_in = 1'b1; run_len = 16'd5;
    cyc(1);
    chk("abort_busy", LEN_W'(busy), 16'd1);
    step_cnt = 0;
    cyc(10);
    chk("abort_pre_steps", LEN_W'(step_cnt), 16'd2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_busy_low", LEN_W'(busy), 16'd0);
    chk("abort_flag", LEN_W'(aborted), 16'd1);
    chk("abort_steps_done", steps_done, 16'd2);
    step_cnt = 0;
    cyc(20);
    chk("abort_no_more_steps", LEN_W'(step_cnt), 16'd0);
    chk("abort_steps_frozen", steps_done, 16'd2);
    start_in = 1'b0; done_ack = 1'b1;
    cyc(1);
    done_ack = 1'b0;
    chk("ack_clears_aborted", LEN_W'(aborted), 16'd0);

    // Abort coinciding with the first terminal tick wins over the step.
    start_in = 1'b1; run_len = 16'd5;
    cyc(4);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    chk("abort_prio_step", LEN_W'(step), 16'd0);
    chk("abort_prio_steps_done", steps_done, 16'd0);
    chk("abort_prio_flag", LEN_W'(aborted), 16'd1);
    chk("abort_prio_busy", LEN_W'(busy), 16'd0);
    start_in = 1'b0; done_ack = 1'b1;
    cyc(1);
    done_ack = 1'b0;

    // Start edge mid-run is ignored.
    start_in = 1'b1; run_len = 16'd4;
    cyc(1);
    step_cnt = 0;
    cyc(5);
    start_in = 1'b0;
    cyc(1);
    start_in = 1'b1; run_len = 16'd9;
    cyc(1);
    chk("midrun_still_busy", LEN_W'(busy), 16'd1);
    cyc(9);
    chk("midrun_final_step", LEN_W'(step), 16'd1);
    chk("midrun_done", LEN_W'(done), 16'd1);
    chk("midrun_busy_low", LEN_W'(busy), 16'd0);
    chk("midrun_steps_done", steps_done, 16'd4);
    chk("midrun_step_cnt", LEN_W'(step_cnt), 16'd4);
    cyc(6);
    chk("midrun_no_restart", LEN_W'(busy), 16'd0);

    // done_ack and a new start in the same cycle while DONE: start wins.
    start_in = 1'b0;
    cyc(1);
    start_in = 1'b1; run_len = 16'd2; done_ack = 1'b1;
    cyc(1);
    done_ack = 1'b0;
    chk("ackstart_busy", LEN_W'(busy), 16'd1);
    chk("ackstart_done_cleared", LEN_W'(done), 16'd0);
    chk("ackstart_steps_done", steps_done, 16'd0);
    step_cnt = 0;
    cyc(8);
    chk("ackstart_done", LEN_W'(done), 16'd1);
    chk("ackstart_steps", LEN_W'(step_cnt), 16'd2);
    chk("ackstart_steps_done_end", steps_done, 16'd2);

    // Async reset between edges, while a step pulse is high.
    start_in = 1'b0; done_ack = 1'b1;
    cyc(1);
    done_ack = 1'b0;
    start_in = 1'b1; run_len = 16'd3;
    cyc(5);
    chk("arst_pre_step", LEN_W'(step), 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", LEN_W'(busy), 16'd0);
    chk("arst_step", LEN_W'(step), 16'd0);
    chk("arst_steps_done", steps_done, 16'd0);
    #2 reset = 1'b0;
    start_in = 1'b0;
    cyc(1);
    start_in = 1'b1;
    cyc(1);
    chk("arst_restart_busy", LEN_W'(busy), 16'd1);
    step_cnt = 0;
    cyc(12);
    chk("arst_restart_done", LEN_W'(done), 16'd1);
    chk("arst_restart_steps", LEN_W'(step_cnt), 16'd3);
    chk("arst_restart_steps_done", steps_done, 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
